// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
// bus_arbiter
//   Arbitrates the shared 16-bit system bus among three masters (OAM DMA, debug
//   master, CPU). The winner's request is latched and driven onto the bus for a
//   fixed number of cycles. A read returns its data with a one-cycle done strobe.
//   Locked DMA beats run back-to-back without an idle gap, up to LOCK_MAX beats.
//
//   Parameters:
//     ACC_CYCLES  cycles bus_re/bus_we are held per access (>=1)
//     LOCK_MAX    max consecutive locked DMA beats before a forced release
//
//   Ports:
//     clk, rst                     clock; asynchronous active-low reset
//     {dma,dbg,cpu}_req/_we/_addr/_wdata   per-master request (level) and payload
//     {dma,dbg,cpu}_gnt            1-cycle pulse: request latched
//     {dma,dbg,cpu}_done           1-cycle pulse: access complete, rdata valid
//     dma_lock                     keep DMA ownership for back-to-back beats
//     cpu_stall                    cpu_req while the CPU does not own the bus
//     bus_addr/bus_wdata/bus_we/bus_re   bus drive toward the address decode
//     bus_rdata                    read data from the bus
//     rdata                        captured read data, held until next read
//
//   Build option:
//     ARB_ROUND_ROBIN_EN  when defined, dbg/cpu ties alternate (the one served
//                         last loses the next tie; pointer resets favouring dbg).
//                         When undefined, dbg always beats cpu. DMA always wins.

module bus_arbiter #(
    parameter int ACC_CYCLES = 2,
    parameter int LOCK_MAX   = 160
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_done,
    input  logic        dma_lock,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic        cpu_stall,

    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  rdata
);

    localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int BW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(LOCK_MAX);

    // Owner / winner encoding, one-hot: bit0 dma, bit1 dbg, bit2 cpu.
    localparam logic [2:0] OWN_NONE = 3'b000;
    localparam logic [2:0] OWN_DMA  = 3'b001;
    localparam logic [2:0] OWN_DBG  = 3'b010;
    localparam logic [2:0] OWN_CPU  = 3'b100;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t        state;
    logic [2:0]    owner;
    logic [CW-1:0] cnt;
    logic [BW-1:0] beats;

    logic [2:0]    win;
    logic          tie_cpu;
    logic          sel_we;
    logic [15:0]   sel_addr;
    logic [7:0]    sel_wdata;
    logic          last_cyc;
    logic          relock;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = cpu wins the next dbg/cpu tie. Flipped whenever one of them is granted
    // from IDLE, so the one just served yields next time.
    logic rr_cpu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_cpu <= 1'b0;
        else if (state == IDLE && (win[1] || win[2]))
            rr_cpu <= win[1];
    end

    assign tie_cpu = rr_cpu;
`else
    assign tie_cpu = 1'b0;
`endif

    // Winner selection; DMA is unconditionally highest.
    always_comb begin
        win = OWN_NONE;
        if (dma_req)
            win = OWN_DMA;
        else if (dbg_req && cpu_req)
            win = tie_cpu ? OWN_CPU : OWN_DBG;
        else if (dbg_req)
            win = OWN_DBG;
        else if (cpu_req)
            win = OWN_CPU;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (win)
            OWN_DMA: begin sel_we = dma_we; sel_addr = dma_addr; sel_wdata = dma_wdata; end
            OWN_DBG: begin sel_we = dbg_we; sel_addr = dbg_addr; sel_wdata = dbg_wdata; end
            OWN_CPU: begin sel_we = cpu_we; sel_addr = cpu_addr; sel_wdata = cpu_wdata; end
            default: ;
        endcase
    end

    assign last_cyc = (cnt == CNT_LAST);
    // Continue a locked DMA burst straight into the next beat, bounded by LOCK_MAX.
    assign relock   = (owner == OWN_DMA) && dma_lock && dma_req && (beats < BEAT_MAX);

    // cpu_stall is intentionally combinational so the CPU halts in the same
    // cycle it raises a request it cannot get.
    assign cpu_stall = cpu_req && !owner[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            cnt       <= '0;
            beats     <= '0;
            dma_gnt   <= 1'b0;
            dbg_gnt   <= 1'b0;
            cpu_gnt   <= 1'b0;
            dma_done  <= 1'b0;
            dbg_done  <= 1'b0;
            cpu_done  <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            rdata     <= '0;
        end else begin
            {cpu_gnt, dbg_gnt, dma_gnt}    <= 3'b000;
            {cpu_done, dbg_done, dma_done} <= 3'b000;

            unique case (state)
                IDLE: begin
                    bus_we <= 1'b0;
                    bus_re <= 1'b0;
                    owner  <= OWN_NONE;
                    if (win != OWN_NONE) begin
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        bus_we    <= sel_we;
                        bus_re    <= !sel_we;
                        owner     <= win;
                        {cpu_gnt, dbg_gnt, dma_gnt} <= win;
                        cnt       <= '0;
                        beats     <= BW'(1);
                        state     <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!last_cyc) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        // bus_we still reflects the latched direction here.
                        if (!bus_we)
                            rdata <= bus_rdata;
                        {cpu_done, dbg_done, dma_done} <= owner;
                        cnt <= '0;
                        if (relock) begin
                            bus_addr  <= dma_addr;
                            bus_wdata <= dma_wdata;
                            bus_we    <= dma_we;
                            bus_re    <= !dma_we;
                            dma_gnt   <= 1'b1;
                            beats     <= beats + BW'(1);
                        end else begin
                            bus_we <= 1'b0;
                            bus_re <= 1'b0;
                            owner  <= OWN_NONE;
                            beats  <= '0;
                            state  <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    a_owner_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(owner));
    a_gnt_onehot:   assert property (@(posedge clk) disable iff (!rst)
                                     $onehot0({dma_gnt, dbg_gnt, cpu_gnt}));
    a_done_onehot:  assert property (@(posedge clk) disable iff (!rst)
                                     $onehot0({dma_done, dbg_done, cpu_done}));

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        dma_req, dma_we, dma_lock, dbg_req, dbg_we, cpu_req, cpu_we;
    logic [15:0] dma_addr, dbg_addr, cpu_addr;
    logic [7:0]  dma_wdata, dbg_wdata, cpu_wdata;

    // Main DUT (LOCK_MAX = 160)
    logic        dma_gnt, dma_done, dbg_gnt, dbg_done, cpu_gnt, cpu_done, cpu_stall;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata, rdata;
    logic        bus_we, bus_re;

    // Second DUT (LOCK_MAX = 4), same inputs
    logic        q_dma_gnt, q_dma_done, q_dbg_gnt, q_dbg_done, q_cpu_gnt, q_cpu_done, q_cpu_stall;
    logic [15:0] q_bus_addr;
    logic [7:0]  q_bus_wdata, q_bus_rdata, q_rdata;
    logic        q_bus_we, q_bus_re;

    // Memory model: read data is a fixed function of the address.
    assign bus_rdata   = bus_addr[7:0] ^ 8'h5A;
    assign q_bus_rdata = q_bus_addr[7:0] ^ 8'h5A;

    bus_arbiter #(.ACC_CYCLES(2), .LOCK_MAX(160)) dut (
        .clk(clk), .rst(rst),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_lock(dma_lock),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .rdata(rdata)
    );

    bus_arbiter #(.ACC_CYCLES(2), .LOCK_MAX(4)) dut4 (
        .clk(clk), .rst(rst),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(q_dma_gnt), .dma_done(q_dma_done), .dma_lock(dma_lock),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(q_dbg_gnt), .dbg_done(q_dbg_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(q_cpu_gnt), .cpu_done(q_cpu_done), .cpu_stall(q_cpu_stall),
        .bus_addr(q_bus_addr), .bus_wdata(q_bus_wdata), .bus_we(q_bus_we), .bus_re(q_bus_re),
        .bus_rdata(q_bus_rdata), .rdata(q_rdata)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: one entry per granted beat of the main DUT, popped on done.
    typedef struct {
        int         who;   // 0 dma, 1 dbg, 2 cpu
        logic [7:0] rd;
    } sb_t;
    sb_t        sb_q[$];
    logic [7:0] last_rd = 8'h00;
    bit         sb_en   = 1'b1;

    function automatic void push_exp(int who, logic we, logic [15:0] addr);
        sb_t e;
        if (!we) last_rd = addr[7:0] ^ 8'h5A;
        e.who = who;
        e.rd  = last_rd;
        sb_q.push_back(e);
    endfunction

    initial forever begin
        @(negedge clk);
        if (sb_en && rst && (dma_done || dbg_done || cpu_done)) begin
            int who;
            sb_t e;
            who = dma_done ? 0 : (dbg_done ? 1 : 2);
            checks++;
            if ($countones({dma_done, dbg_done, cpu_done}) != 1) begin
                errors++;
                $display("FAIL sb_done_onehot got %b want one-hot", {dma_done, dbg_done, cpu_done});
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done got master %0d want no done", who);
            end else begin
                e = sb_q.pop_front();
                if (who !== e.who || rdata !== e.rd) begin
                    errors++;
                    $display("FAIL sb_done got master %0d rdata %h want master %0d rdata %h",
                             who, rdata, e.who, e.rd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want bench completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        {dma_req, dbg_req, cpu_req, dma_lock} = '0;
        tick();
        tick();
        sb_q.delete();
        last_rd = 8'h00;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_req = 1'b1;
        #3;
        checks++;
        if ({dma_gnt, dma_done, dbg_gnt, dbg_done, cpu_gnt, cpu_done, bus_we, bus_re} !== 8'h00 ||
            bus_addr !== 16'h0 || bus_wdata !== 8'h0 || rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs got strobes %b addr %h wdata %h rdata %h want all 0",
                     {dma_gnt, dma_done, dbg_gnt, dbg_done, cpu_gnt, cpu_done, bus_we, bus_re},
                     bus_addr, bus_wdata, rdata);
        end
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall_hi got %b want 1", cpu_stall);
        end
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall_lo got %b want 0", cpu_stall);
        end
        checks++;
        if ({q_dma_gnt, q_cpu_gnt, q_bus_we, q_bus_re} !== 4'h0 || q_bus_addr !== 16'h0) begin
            errors++; $display("FAIL reset_dut4 got %b %h want 0", {q_dma_gnt, q_cpu_gnt, q_bus_we, q_bus_re}, q_bus_addr);
        end
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_we = 1'b0; cpu_addr = 16'hC000; cpu_req = 1'b1;
        #1;
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++; $display("FAIL rd_c0_stall got %b want 1", cpu_stall);
        end
        tick();  // cycle 1
        checks++;
        if (cpu_gnt !== 1'b1 || bus_re !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 16'hC000 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL rd_c1 got gnt %b re %b we %b addr %h stall %b want 1 1 0 c000 0",
                     cpu_gnt, bus_re, bus_we, bus_addr, cpu_stall);
        end
        push_exp(2, 1'b0, cpu_addr);
        cpu_req = 1'b0;
        tick();  // cycle 2
        checks++;
        if (cpu_gnt !== 1'b0 || bus_re !== 1'b1 || cpu_done !== 1'b0) begin
            errors++; $display("FAIL rd_c2 got gnt %b re %b done %b want 0 1 0", cpu_gnt, bus_re, cpu_done);
        end
        tick();  // cycle 3
        checks++;
        if (cpu_done !== 1'b1 || rdata !== 8'h5A || bus_re !== 1'b0) begin
            errors++; $display("FAIL rd_c3 got done %b rdata %h re %b want 1 5a 0", cpu_done, rdata, bus_re);
        end
        tick();
        checks++;
        if (cpu_done !== 1'b0) begin
            errors++; $display("FAIL rd_c4 got done %b want 0", cpu_done);
        end
    endtask

    task automatic test_write();
        cpu_we = 1'b1; cpu_addr = 16'hFF40; cpu_wdata = 8'h91; cpu_req = 1'b1;
        tick();
        checks++;
        if (cpu_gnt !== 1'b1 || bus_we !== 1'b1 || bus_re !== 1'b0 || bus_wdata !== 8'h91 || bus_addr !== 16'hFF40) begin
            errors++;
            $display("FAIL wr_c1 got gnt %b we %b re %b wdata %h addr %h want 1 1 0 91 ff40",
                     cpu_gnt, bus_we, bus_re, bus_wdata, bus_addr);
        end
        push_exp(2, 1'b1, cpu_addr);
        cpu_req = 1'b0;
        tick();
        checks++;
        if (bus_we !== 1'b1) begin
            errors++; $display("FAIL wr_c2 got we %b want 1", bus_we);
        end
        tick();
        checks++;
        if (bus_we !== 1'b0 || cpu_done !== 1'b1 || rdata !== 8'h5A) begin
            errors++; $display("FAIL wr_c3 got we %b done %b rdata %h want 0 1 5a", bus_we, cpu_done, rdata);
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_priority();
        int order[3];
        int n = 0;
        int exp_order[3];
        // A lone dbg access first, so dbg is the last of dbg/cpu served.
        dbg_we = 1'b0; dbg_addr = 16'h0011; dbg_req = 1'b1;
        for (int c = 0; c < 10 && dbg_req; c++) begin
            tick();
            if (dbg_gnt) begin push_exp(1, dbg_we, dbg_addr); dbg_req = 1'b0; end
        end
        tick(); tick(); tick();

        dma_we = 1'b0; dma_addr = 16'hFE10;
        dbg_addr = 16'h8020; cpu_addr = 16'hC030;
        dma_req = 1'b1; dbg_req = 1'b1; cpu_req = 1'b1;
        for (int c = 0; c < 40 && n < 3; c++) begin
            tick();
            if (dma_gnt) begin order[n] = 0; n++; push_exp(0, dma_we, dma_addr); dma_req = 1'b0; end
            if (dbg_gnt) begin order[n] = 1; n++; push_exp(1, dbg_we, dbg_addr); dbg_req = 1'b0; end
            if (cpu_gnt) begin order[n] = 2; n++; push_exp(2, cpu_we, cpu_addr); cpu_req = 1'b0; end
        end
        {dma_req, dbg_req, cpu_req} = '0;
        tick(); tick(); tick();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 2, 1};
`else
        exp_order = '{0, 1, 2};
`endif
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL prio_count got %0d want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (order[i] !== exp_order[i]) begin
                    errors++; $display("FAIL prio_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_lock_burst();
        int g = 0, d = 0, done_c = -1, cpu_c = -1;
        int addr_err = 0, gap_err = 0, stall_err = 0, early = 0;
        do_reset();
        dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 16'hFE00; dma_wdata = 8'h00; dma_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 16'hC100; cpu_req = 1'b1;
        for (int c = 0; c < 800 && cpu_c < 0; c++) begin
            tick();
            if (dma_done) d++;
            if (d == 160 && done_c < 0) done_c = c;
            if (dma_gnt) begin
                if (bus_addr !== dma_addr || bus_wdata !== dma_wdata) addr_err++;
                push_exp(0, dma_we, dma_addr);
                g++;
                if (g == 160) begin
                    dma_req = 1'b0; dma_lock = 1'b0;
                end else begin
                    dma_addr = 16'hFE00 + 16'(g); dma_wdata = 8'(g);
                end
            end
            if (cpu_gnt) begin
                cpu_c = c;
                if (d < 160) early++;
                push_exp(2, cpu_we, cpu_addr);
                cpu_req = 1'b0;
            end else if (cpu_stall !== 1'b1) stall_err++;
            if (g > 0 && d < 160 && bus_we !== 1'b1) gap_err++;
        end
        tick(); tick(); tick();
        checks++;
        if (g !== 160) begin errors++; $display("FAIL lock_beats got %0d want 160", g); end
        checks++;
        if (addr_err !== 0) begin errors++; $display("FAIL lock_addr got %0d bad beats want 0", addr_err); end
        checks++;
        if (gap_err !== 0) begin errors++; $display("FAIL lock_gap got %0d idle cycles want 0", gap_err); end
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL lock_stall got %0d unstalled cycles want 0", stall_err); end
        checks++;
        if (early !== 0 || cpu_c !== done_c + 1) begin
            errors++; $display("FAIL lock_cpu_gnt got cycle %0d early %0d want cycle %0d", cpu_c, early, done_c + 1);
        end
    endtask

    task automatic test_lock_max();
        int gc[6];
        int exp_gap[5] = '{2, 2, 2, 3, 2};
        int g = 0, cpu_c = -1, early = 0;
        do_reset();
        sb_en = 1'b0;
        dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 16'hC200; dma_req = 1'b1;
        cpu_we = 1'b0; cpu_addr = 16'hC300; cpu_req = 1'b1;
        for (int c = 0; c < 100 && cpu_c < 0; c++) begin
            tick();
            if (q_dma_gnt) begin
                if (g < 6) gc[g] = c;
                g++;
                if (g == 6) begin dma_req = 1'b0; dma_lock = 1'b0; end
                else dma_addr = dma_addr + 16'd1;
            end
            if (q_cpu_gnt) begin
                cpu_c = c;
                if (g < 6) early++;
                cpu_req = 1'b0;
            end
        end
        tick(); tick(); tick();
        checks++;
        if (g !== 6) begin
            errors++; $display("FAIL lmax_beats got %0d want 6", g);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gc[i+1] - gc[i] !== exp_gap[i]) begin
                    errors++; $display("FAIL lmax_gap[%0d] got %0d want %0d", i, gc[i+1] - gc[i], exp_gap[i]);
                end
            end
            checks++;
            if (early !== 0 || cpu_c !== gc[5] + 3) begin
                errors++; $display("FAIL lmax_cpu_gnt got cycle %0d early %0d want cycle %0d", cpu_c, early, gc[5] + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit stray = 1'b0;
        do_reset();
        sb_en = 1'b1;
        dbg_we = 1'b0; dbg_addr = 16'h1234; dbg_req = 1'b1;
        tick();
        checks++;
        if (dbg_gnt !== 1'b1 || bus_re !== 1'b1) begin
            errors++; $display("FAIL rmid_gnt got gnt %b re %b want 1 1", dbg_gnt, bus_re);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({dma_gnt, dma_done, dbg_gnt, dbg_done, cpu_gnt, cpu_done, bus_we, bus_re} !== 8'h00 ||
            bus_addr !== 16'h0 || bus_wdata !== 8'h0 || rdata !== 8'h0) begin
            errors++;
            $display("FAIL rmid_async got strobes %b addr %h rdata %h want all 0",
                     {dma_gnt, dma_done, dbg_gnt, dbg_done, cpu_gnt, cpu_done, bus_we, bus_re}, bus_addr, rdata);
        end
        dbg_req = 1'b0;
        sb_q.delete();
        last_rd = 8'h00;
        tick(); tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (dbg_done) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL rmid_no_done got done 1 want 0"); end
        dbg_req = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (dbg_gnt) begin seen = 1'b1; push_exp(1, dbg_we, dbg_addr); dbg_req = 1'b0; end
        end
        dbg_req = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (!seen || rdata !== 8'h6E) begin
            errors++; $display("FAIL rmid_reissue got gnt %b rdata %h want 1 6e", seen, rdata);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++; $display("FAIL rmid_sb_drain got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        {dma_req, dma_we, dma_lock, dbg_req, dbg_we, cpu_req, cpu_we} = '0;
        {dma_addr, dbg_addr, cpu_addr} = '0;
        {dma_wdata, dbg_wdata, cpu_wdata} = '0;
        test_reset();
        test_cpu_read();
        test_write();
        test_priority();
        test_lock_burst();
        test_lock_max();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
